// File: rtl/video_scan_gen_if.sv
// video_scan_gen_if - register write port of video_scan_gen.
// The master drives strobe/address/data; the slave returns a one-cycle ack.
interface video_scan_gen_if;
    logic        i_wr_stb;
    logic [1:0]  i_wr_addr;
    logic [15:0] i_wr_data;
    logic        o_wr_ack;

    modport master (output i_wr_stb, output i_wr_addr, output i_wr_data, input o_wr_ack);
    modport slave  (input i_wr_stb, input i_wr_addr, input i_wr_data, output o_wr_ack);
endinterface

// File: rtl/video_scan_gen.sv
// video_scan_gen - raster scan timing generator with text-cell coordinates,
// frame counter and optional frame-synchronous scroll offsets.
// Optional feature: define VIDEO_SCAN_GEN_SCROLL_EN to build the scroll
// registers; without it o_scan_x/o_scan_y simply follow the counters.
module video_scan_gen #(
    parameter int HSZ      = 10,
    parameter int VSZ      = 10,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int GLYPH_W  = 8,
    parameter int GLYPH_H  = 12,
    parameter int TRW      = 6
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       i_pix_ce,
    video_scan_gen_if.slave            wr,
    output logic [HSZ-1:0]             o_hcount,
    output logic [VSZ-1:0]             o_vcount,
    output logic                       o_de,
    output logic                       o_hsync,
    output logic                       o_vsync,
    output logic                       o_sol,
    output logic                       o_sof,
    output logic [$clog2(GLYPH_W)-1:0] o_cell_col,
    output logic [3:0]                 o_glyph_row,
    output logic [TRW-1:0]             o_text_row,
    output logic [5:0]                 o_frame_count,
    output logic [HSZ-1:0]             o_scan_x,
    output logic [VSZ-1:0]             o_scan_y
);

    localparam int CW = $clog2(GLYPH_W);

    localparam logic [HSZ-1:0] H_LAST = HSZ'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [HSZ-1:0] H_ACT  = HSZ'(H_ACTIVE);
    localparam logic [HSZ-1:0] H_SS   = HSZ'(H_ACTIVE + H_FP);
    localparam logic [HSZ-1:0] H_SE   = HSZ'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VSZ-1:0] V_LAST = VSZ'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [VSZ-1:0] V_ACT  = VSZ'(V_ACTIVE);
    localparam logic [VSZ-1:0] V_SS   = VSZ'(V_ACTIVE + V_FP);
    localparam logic [VSZ-1:0] V_SE   = VSZ'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [3:0]     G_LAST = 4'(GLYPH_H - 1);
    localparam logic           HS_ACT = 1'(HS_POL);
    localparam logic           VS_ACT = 1'(VS_POL);

    logic           run;
    logic           run_next;
    logic           wr_ctrl;
    logic           clr_fc;
    logic           adv;
    logic           h_wrap;
    logic           v_wrap;
    logic [HSZ-1:0] scroll_x;
    logic [VSZ-1:0] scroll_y;
    logic           data_unused;

    // Not every data bit is stored; fold the rest into one sink.
    assign data_unused = ^wr.i_wr_data;

    // Advance/wrap decode. A ctrl write takes effect on the very edge that
    // samples it, so its run bit gates that same edge's advance.
    always_comb begin
        wr_ctrl  = wr.i_wr_stb && (wr.i_wr_addr == 2'd2);
        run_next = wr_ctrl ? wr.i_wr_data[0] : run;
        clr_fc   = wr_ctrl && wr.i_wr_data[1];
        adv      = i_pix_ce && run_next;
        h_wrap   = (o_hcount == H_LAST);
        v_wrap   = h_wrap && (o_vcount == V_LAST);
    end

    // Control register and write acknowledge, independent of pixel enable.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            run         <= 1'b1;
            wr.o_wr_ack <= 1'b0;
        end else begin
            run         <= run_next;
            wr.o_wr_ack <= wr.i_wr_stb;
        end
    end

    // Horizontal/vertical counters with glyph-row and text-row tracking.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            o_hcount    <= '0;
            o_vcount    <= '0;
            o_glyph_row <= '0;
            o_text_row  <= '0;
        end else if (adv) begin
            if (h_wrap) begin
                o_hcount <= '0;
                if (v_wrap) begin
                    o_vcount    <= '0;
                    o_glyph_row <= '0;
                    o_text_row  <= '0;
                end else begin
                    o_vcount <= o_vcount + 1'b1;
                    if (o_glyph_row == G_LAST) begin
                        o_glyph_row <= '0;
                        o_text_row  <= o_text_row + 1'b1;
                    end else begin
                        o_glyph_row <= o_glyph_row + 1'b1;
                    end
                end
            end else begin
                o_hcount <= o_hcount + 1'b1;
            end
        end
    end

    // Frame counter; a clear request beats a simultaneous frame wrap.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            o_frame_count <= '0;
        end else if (clr_fc) begin
            o_frame_count <= '0;
        end else if (adv && v_wrap) begin
            o_frame_count <= o_frame_count + 1'b1;
        end
    end

`ifdef VIDEO_SCAN_GEN_SCROLL_EN
    logic [HSZ-1:0] shadow_x;
    logic [VSZ-1:0] shadow_y;

    // Shadow scroll registers take writes; active copies reload at frame start,
    // so a shadow write on the wrap edge only lands the following frame.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            shadow_x <= '0;
            shadow_y <= '0;
            scroll_x <= '0;
            scroll_y <= '0;
        end else begin
            if (wr.i_wr_stb && (wr.i_wr_addr == 2'd0)) shadow_x <= wr.i_wr_data[HSZ-1:0];
            if (wr.i_wr_stb && (wr.i_wr_addr == 2'd1)) shadow_y <= wr.i_wr_data[VSZ-1:0];
            if (adv && v_wrap) begin
                scroll_x <= shadow_x;
                scroll_y <= shadow_y;
            end
        end
    end
`else
    assign scroll_x = '0;
    assign scroll_y = '0;
`endif

    // Zero-latency decodes from the current counter values.
    always_comb begin
        o_de       = (o_hcount < H_ACT) && (o_vcount < V_ACT);
        o_hsync    = ((o_hcount >= H_SS) && (o_hcount < H_SE)) ? HS_ACT : ~HS_ACT;
        o_vsync    = ((o_vcount >= V_SS) && (o_vcount < V_SE)) ? VS_ACT : ~VS_ACT;
        o_sol      = (o_hcount == '0);
        o_sof      = (o_hcount == '0) && (o_vcount == '0);
        o_cell_col = o_hcount[CW-1:0];
        o_scan_x   = o_hcount + scroll_x;
        o_scan_y   = o_vcount + scroll_y;
    end

endmodule

// File: doc/video_scan_gen.md
VIDEO_SCAN_GEN -- requirements
Module: video_scan_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning): HSZ 10 h-count width; VSZ 10 v-count width; H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48 (horizontal pixels); V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33 (vertical lines); HS_POL 0, VS_POL 0 (sync active level); GLYPH_W 8 (power of 2); GLYPH_H 12; TRW 6 text-row width.
REQ-002 Ports SHALL be (name direction width meaning): clk_i in 1 system clock; rstn_i in 1 reset; i_pix_ce in 1 pixel enable; i_wr_stb in 1 register write strobe; i_wr_addr in 2 register select; i_wr_data in 16 write data; o_wr_ack out 1 write acknowledge; o_hcount out HSZ; o_vcount out VSZ; o_de out 1 active video; o_hsync out 1; o_vsync out 1; o_sol out 1 start-of-line; o_sof out 1 start-of-frame; o_cell_col out log2(GLYPH_W); o_glyph_row out 4; o_text_row out TRW; o_frame_count out 6; o_scan_x out HSZ scrolled column; o_scan_y out VSZ scrolled row.
REQ-003 One clock; reset is asynchronous and active-low: clk_i is the single clock, rstn_i the reset.

Function
REQ-004 All state SHALL update on posedge clk_i only in cycles where i_pix_ce=1 and ctrl.run=1, except the register port (REQ-013..015).
REQ-005 o_hcount SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H params) then wrap to 0; o_vcount SHALL increment on each h wrap, wrapping 0 after V_TOTAL-1.
REQ-006 o_de SHALL be 1 iff hcount<H_ACTIVE and vcount<V_ACTIVE, decoded combinationally from the current counters (zero latency).
REQ-007 o_hsync SHALL equal HS_POL when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL; o_vsync likewise with V params and VS_POL.
REQ-008 o_sol SHALL be 1 while hcount=0; o_sof SHALL be 1 while hcount=0 and vcount=0.
REQ-009 o_cell_col SHALL equal hcount[log2(GLYPH_W)-1:0].
REQ-010 On each h wrap: if the wrap is also a v wrap, glyph_row and text_row SHALL load 0; else if glyph_row=GLYPH_H-1, glyph_row SHALL load 0 and text_row increment (mod 2^TRW); else glyph_row SHALL increment.
REQ-011 o_frame_count SHALL increment mod 64 on each v wrap; 63 -> 0.
REQ-012 o_scan_x SHALL equal (hcount + scroll_x) mod 2^HSZ; o_scan_y SHALL equal (vcount + scroll_y) mod 2^VSZ; both combinational.
REQ-013 Registers: addr 0 shadow scroll_x [HSZ-1:0]; addr 1 shadow scroll_y [VSZ-1:0]; addr 2 ctrl: bit0 run, bit1 frame-count clear (write-1 pulse, not stored); addr 3 reserved, writes ignored; excess data bits ignored.
REQ-014 A write SHALL take effect on the clk_i edge sampling i_wr_stb=1 regardless of i_pix_ce/run; o_wr_ack SHALL pulse 1 for exactly the following clk_i cycle, for every strobe including addr 3; back-to-back strobes each acked.
REQ-015 Active scroll_x/scroll_y SHALL load from shadows on the advancing edge where counters wrap to (0,0); a shadow write in that same edge updates only the shadow (active takes it next frame).
REQ-016 Frame-count clear coinciding with a v wrap SHALL win: frame_count=0.
REQ-017 run=0 SHALL freeze all counters and outputs at current values; run 0->1 resumes from the frozen position without skip.

Reset
REQ-018 rstn_i low SHALL asynchronously force: hcount=0, vcount=0, glyph_row=0, text_row=0, frame_count=0, shadow and active scroll=0, run=1, o_wr_ack=0; hence o_de=1, o_sol=1, o_sof=1, o_hsync=~HS_POL, o_vsync=~VS_POL, scan_x=scan_y=0.
REQ-019 Reset asserted mid-frame or mid-write SHALL discard the pending write and ack; counting restarts at (0,0) on the first advancing edge after release.

Configuration
REQ-020 Macro VIDEO_SCAN_GEN_SCROLL_EN defined: scroll registers and REQ-012/015 as specified; undefined: no scroll storage, addr 0/1 writes acked but ignored, o_scan_x=hcount, o_scan_y=vcount.

Verification
REQ-021 Reset release, i_pix_ce=1 constant, defaults -> hsync low for hcount 656..751, vsync low for vcount 490..491, o_sof every 420000 cycles, o_de count 307200 per frame.
REQ-022 i_pix_ce=1 every 4th cycle -> counters advance once per 4 clk_i, o_hcount 799 -> 0 with vcount+1.
REQ-023 Write addr0=5 mid-frame -> o_scan_x=hcount until next (0,0), then hcount+5; with hcount=1020 (HSZ=10) scan_x=1; write on the wrap edge itself -> delayed one further frame; macro undefined -> scan_x=hcount always.
REQ-024 Defaults, frame start -> glyph_row 0..11 repeating, text_row=40 at line 480, both 0 after vcount wrap; frame_count 63 -> 0 after 64 frames.
REQ-025 Write addr2=0 at hcount=100 -> counters hold 100 indefinitely, ack one cycle after strobe; write addr2=1 -> resumes at 101; write addr2=3 on v-wrap edge -> frame_count=0.
REQ-026 rstn_i low at hcount=300,vcount=200 with i_wr_stb high -> immediate zeroed outputs, no ack, shadow unchanged (0).
